// File: rtl/param_pkg.sv
// ============================================================================
// Module      : param_pkg
// Description : Shared data-bus widths, arbiter state and captured-request type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_pkg;

    localparam int DBUS_AW          = 32;
    localparam int DBUS_DW          = 32;
    localparam int DBUS_ISEL        = 4;
    localparam int DBUS_NUM_MASTERS = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [DBUS_AW-1:0]   adr;
        logic [DBUS_DW-1:0]   dat;
        logic                 we;
        logic [DBUS_ISEL-1:0] sel;
    } dbus_req_t;

endpackage

`default_nettype wire

// File: rtl/cpu_dbus_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requester at or after i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [IW-1:0]      o_idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    // Rotating the doubled vector puts the pointer's requester at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        int w_sum;
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = int'(i_ptr) + k;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                o_idx = IW'(w_sum);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_dbus_arbiter.sv
// ============================================================================
// Module      : cpu_dbus_arbiter
// Description : N-master to 1-slave round-robin data-bus arbiter, one transfer
//               outstanding. Optional slave-ack timeout: DBUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_dbus_arbiter
    import param_pkg::*;
#(
    parameter int NUM_MASTERS = param_pkg::DBUS_NUM_MASTERS,
    parameter int AW          = param_pkg::DBUS_AW,
    parameter int DW          = param_pkg::DBUS_DW,
    parameter int SW          = param_pkg::DBUS_ISEL,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*SW-1:0]     m_sel_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic                          s_req_o,
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic                          s_we_o,
    output logic [SW-1:0]                 s_sel_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int c_IW = $clog2(NUM_MASTERS);

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          we;
        logic [SW-1:0] sel;
    } cap_req_t;

    arb_state_e      r_state;
    cap_req_t        r_req;
    logic            r_s_req;
    logic [c_IW-1:0] r_grant;
    logic [c_IW-1:0] r_rr_ptr;

    logic            w_arb_valid;
    logic [c_IW-1:0] w_arb_idx;
    logic [c_IW-1:0] w_ptr_next;
    logic            w_timeout;
    logic            w_force;
    logic            w_done;

    rr_arbiter #(
        .NUM_REQ (NUM_MASTERS),
        .IW      (c_IW)
    ) u_rr_arbiter (
        .i_req   (m_req_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    assign w_ptr_next = (int'(r_grant) == NUM_MASTERS - 1) ? '0 : r_grant + 1'b1;

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYC > 255) ? 16 : 8;

    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUSY) && (r_to_cnt == c_TO_W'(TIMEOUT_CYC));
    // A real ack in the timeout cycle takes precedence over the abort.
    assign w_force   = w_timeout && !s_ack_i;
    assign err_o     = w_force;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
    assign w_force          = 1'b0;
    assign err_o            = 1'b0;
`endif

    assign w_done = s_ack_i || w_timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_s_req  <= 1'b0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_state   <= BUSY;
                        r_s_req   <= 1'b1;
                        r_grant   <= w_arb_idx;
                        r_req.adr <= m_adr_i[int'(w_arb_idx)*AW +: AW];
                        r_req.dat <= m_dat_i[int'(w_arb_idx)*DW +: DW];
                        r_req.we  <= m_we_i[w_arb_idx];
                        r_req.sel <= m_sel_i[int'(w_arb_idx)*SW +: SW];
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_s_req  <= 1'b0;
                        r_rr_ptr <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_dat_o = '0;
        if (r_state == BUSY) begin
            m_ack_o[r_grant] = w_done;
            if (!w_force) begin
                m_dat_o = s_dat_i;
            end
        end
    end

    assign s_req_o = r_s_req;
    assign s_adr_o = r_req.adr;
    assign s_dat_o = r_req.dat;
    assign s_we_o  = r_req.we;
    assign s_sel_o = r_req.sel;
    assign grant_o = r_grant;
    assign busy_o  = (r_state == BUSY);

endmodule

`default_nettype wire
